uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  UART receiver, 8N1, LSB first; the receiving end of the team's UART transmitter (test_tx).
//  Recovers bytes from the serial rx line using 16x oversampling.
//  Baud rate is chosen at run time by baud_sel, using the same selector table as the transmitter.
//  Received bytes are presented on a valid/ready handshake; framing and overrun errors are flagged.
// PARAMETERS
//  CLK_FREQ    50_000_000  system clock frequency in Hz
//  OVERSAMPLE  16          oversampling ticks per bit; fixed at 16, the state machine depends on it
// PORTS
//  clk          in   1  system clock, single clock domain
//  rst          in   1  reset, asynchronous, active-high
//  rx           in   1  serial input; asynchronous to clk; idles high
//  baud_sel     in   3  baud rate: 000=4800 001=9600 010=19200 011=38400
//                       100=57600 101=115200 110=230400 111=460800
//  data_out     out  8  last received byte
//  data_valid   out  1  data_out holds an unconsumed byte
//  data_ready   in   1  consumer accepts the byte when data_valid && data_ready
//  busy         out  1  a frame is in progress (state != IDLE)
//  frame_err    out  1  one-cycle pulse: stop bit sampled as 0
//  overrun_err  out  1  one-cycle pulse: good byte completed while data_valid was high
// BEHAVIOUR
//  Reset (asynchronous): state=IDLE; data_out=8'h00; data_valid=0; busy=0; frame_err=0;
//    overrun_err=0; synchroniser flops=1; tick and bit counters=0. Reset mid-frame abandons the frame.
//  Synchroniser: rx passes through 2 flops (rx_s); all logic uses rx_s only.
//  Tick generator
//    DIV = (CLK_FREQ + baud*8) / (baud*16), integer arithmetic; 460800 -> 7 clocks per tick.
//    Tick counter counts 0..DIV-1 and emits a one-clock tick at DIV-1.
//    Counter is cleared on start detect, so sampling phase is aligned to the start edge.
//  baud_sel is latched on start detect; changes mid-frame have no effect until the next frame.
//  FSM, with s = tick count within a bit (0..15) and b = bit index (0..7):
//    IDLE : rx_s==0 -> START, s=0.
//    START: at s==7 (mid-bit), if rx_s==1 -> IDLE (glitch, no flag); else s=0 -> DATA, b=0.
//    DATA : at s==15, shift rx_s into bit b (LSB first). b==7 -> STOP, else b++.
//    STOP : at s==15, sample the stop bit.
//           1, data_valid==0 -> data_out=shift reg; data_valid=1; go to IDLE.
//           1, data_valid==1 -> overrun_err pulse; new byte dropped; old byte kept; go to IDLE.
//           0 -> frame_err pulse; data_out unchanged; go to BREAK.
//    BREAK: wait for rx_s==1, then IDLE (no false start during a long break).
//  Handshake
//    data_valid clears on the cycle after valid&&ready.
//    If acceptance and a new stop-bit commit fall on the same cycle, the new byte is
//    loaded and data_valid stays 1; no overrun.
//  Latency: data_valid rises 1 clk after the stop-bit mid-sample tick, about 9.5 bit times
//    after the start edge, plus 2 clk of synchroniser delay.
//  Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start edge immediately
//    after the stop bit is caught.
//  Error pulses are exactly 1 clk wide and never coincide with a data_valid rise.
// TESTING
//  Clock is 20 ns. The stimulus transmitter drives exact bit times.
//  1. baud_sel=001, send 8'h55 -> data_valid rises ~1.0 ms after the start edge;
//     data_out=8'h55; no error pulses.
//  2. Change baud_sel between frames: 010 sends 8'hAA, then 011 sends 8'hEF
//     -> bytes received in order, data_ready held 1.
//  3. baud_sel=111, send 8'h00 with a 0 stop bit
//     -> frame_err pulses once; data_valid stays 0; FSM holds in BREAK until rx=1.
//  4. Drive rx low for 3 ticks at 9600 -> no byte, no error; busy returns to 0 by mid-start.
//  5. data_ready=0, send 8'h12 then 8'h34
//     -> overrun_err pulses at the second stop bit; data_out stays 8'h12.
//  6. Assert rst mid-data-bit -> all outputs return to reset values immediately;
//     the next full frame 8'hC3 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, run-time baud selection and a
// valid/ready output handshake with framing and overrun error pulses.
module uart_rx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic [2:0] baud_sel,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun_err
);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    localparam logic [3:0] S_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] S_LAST = 4'(OVERSAMPLE - 1);

    state_t      state, state_next;
    logic        rx_meta, rx_s;
    logic [2:0]  baud_q;
    logic [15:0] tick_cnt;
    logic [3:0]  s_cnt;
    logic [2:0]  b_cnt;
    logic [7:0]  shift;
    logic        tick;
    logic        start_det, s_clr, shift_en, commit, ovr, ferr;

    // Last tick-counter value for a baud selector, rounded to the nearest clock.
    function automatic logic [15:0] div_m1(input logic [2:0] sel);
        int baud;
        case (sel)
            3'd0:    baud = 4800;
            3'd1:    baud = 9600;
            3'd2:    baud = 19200;
            3'd3:    baud = 38400;
            3'd4:    baud = 57600;
            3'd5:    baud = 115200;
            3'd6:    baud = 230400;
            default: baud = 460800;
        endcase
        return 16'((CLK_FREQ + baud * 8) / (baud * 16) - 1);
    endfunction

    assign tick = (tick_cnt == div_m1(baud_q));
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_det  = 1'b0;
        s_clr      = 1'b0;
        shift_en   = 1'b0;
        commit     = 1'b0;
        ovr        = 1'b0;
        ferr       = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    start_det  = 1'b1;
                end
            end
            // A start bit that is high again at mid-bit was only a glitch.
            START: begin
                if (tick && s_cnt == S_MID) begin
                    if (rx_s) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                        s_clr      = 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick && s_cnt == S_LAST) begin
                    shift_en = 1'b1;
                    if (b_cnt == 3'd7) state_next = STOP;
                end
            end
            // Leave at mid-stop-bit so an immediately following start edge is seen.
            STOP: begin
                if (tick && s_cnt == S_LAST) begin
                    if (rx_s) begin
                        state_next = IDLE;
                        if (data_valid && !data_ready) ovr = 1'b1;
                        else                           commit = 1'b1;
                    end else begin
                        state_next = BRK;
                        ferr       = 1'b1;
                    end
                end
            end
            BRK: begin
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_q   <= 3'd0;
            tick_cnt <= 16'd0;
            s_cnt    <= 4'd0;
            b_cnt    <= 3'd0;
            shift    <= 8'h00;
        end else begin
            if (start_det) baud_q <= baud_sel;
            if (start_det || state == IDLE || state == BRK || tick) tick_cnt <= 16'd0;
            else                                                    tick_cnt <= tick_cnt + 16'd1;
            if (start_det || s_clr) s_cnt <= 4'd0;
            else if (tick)          s_cnt <= s_cnt + 4'd1;
            if (start_det || s_clr) b_cnt <= 3'd0;
            else if (shift_en)      b_cnt <= b_cnt + 3'd1;
            if (shift_en) shift <= {rx_s, shift[7:1]};
        end
    end

    // A commit coinciding with acceptance reloads the byte and keeps data_valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out    <= 8'h00;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= ferr;
            overrun_err <= ovr;
            if (commit) begin
                data_out   <= shift;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule
